// File: rtl/decimating_streamer_pkg.sv
// Shared constants and result mapping for the
// delta-sigma decimation blocks.
package decimating_streamer_pkg;

  localparam int MAX_W = 16;

  function automatic int win_len(input int osr_log2);
    return 1 << osr_log2;
  endfunction

  // Clamp the ones count to OSR_LOG2 bits, then justify to data_w.
  function automatic logic [MAX_W-1:0] map_result(
    input logic [MAX_W:0] total,
    input int             osr_log2,
    input int             data_w
  );
    logic [MAX_W:0]   lim;
    logic [MAX_W-1:0] c;
    lim = (17'd1 << osr_log2) - 17'd1;
    c   = (total > lim) ? lim[MAX_W-1:0] : total[MAX_W-1:0];
    if (data_w <= osr_log2)
      return c >> (osr_log2 - data_w);
    return c << (data_w - osr_log2);
  endfunction

endpackage

// File: rtl/decimating_streamer_ones_window_counter.sv
// Counts ones over back-to-back windows of 2^OSR_LOG2
// qualified bits; flags the bit that closes a window.
module ones_window_counter
  import decimating_streamer_pkg::*;
#(
  parameter int OSR_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adcInput,
  input  logic              sampleEn,
  input  logic              restart,
  output logic              windowDone,
  output logic [OSR_LOG2:0] total
);

  logic [OSR_LOG2-1:0] bitCnt;
  logic [OSR_LOG2:0]   onesAcc;
  logic                qual;

  assign qual       = sampleEn & ~restart;
  assign total      = onesAcc + {{OSR_LOG2{1'b0}}, adcInput};
  assign windowDone = qual & (&bitCnt);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      bitCnt  <= '0;
      onesAcc <= '0;
    end else if (qual) begin
      bitCnt  <= bitCnt + 1'b1;
      onesAcc <= windowDone ? '0 : total;
    end
  end

endmodule

// File: rtl/decimating_streamer.sv
// Bitstream-to-sample decimator with a valid/ready
// output register and sticky overrun flag.
module decimating_streamer
  import decimating_streamer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OSR_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adcInput,
  input  logic              sampleEn,
  input  logic              restart,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              overrun,
  input  logic              overrunClr
);

  logic              windowDone;
  logic [OSR_LOG2:0] total;
  logic [MAX_W:0]    totalX;
  logic [MAX_W-1:0]  mapped;
  logic [DATA_W-1:0] result;
  logic              xfer;
  logic              canLoad;
  logic              drop;

  ones_window_counter #(
    .OSR_LOG2(OSR_LOG2)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .adcInput  (adcInput),
    .sampleEn  (sampleEn),
    .restart   (restart),
    .windowDone(windowDone),
    .total     (total)
  );

  always_comb begin
    totalX = '0;
    totalX[OSR_LOG2:0] = total;
    mapped = map_result(totalX, OSR_LOG2, DATA_W);
    result = mapped[DATA_W-1:0];
  end

  assign xfer    = outValid & outReady;
  assign canLoad = ~outValid | outReady;
  // A full register that is not draining keeps its sample.
  assign drop    = windowDone & ~canLoad;

  always_ff @(posedge clk) begin
    if (rst) begin
      outData  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (windowDone && canLoad) begin
        outData  <= result;
        outValid <= 1'b1;
      end else if (xfer) begin
        outValid <= 1'b0;
      end
      if (drop)
        overrun <= 1'b1;
      else if (overrunClr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decimating_streamer.sv
// Scoreboard bench for decimating_streamer.
module tb_decimating_streamer;

  logic       clk = 1'b0;
  logic       rst, adcInput, sampleEn, restart;
  logic       outReady, overrunClr;
  logic [7:0] outData;
  logic       outValid, overrun;

  logic       adc2, en2, rdy2, zero2;
  logic [3:0] od4;
  logic       ov4, or4;
  logic [9:0] od10;
  logic       ov10, or10;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  int tq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  decimating_streamer #(.DATA_W(8), .OSR_LOG2(8)) dut (
    .clk(clk), .rst(rst), .adcInput(adcInput),
    .sampleEn(sampleEn), .restart(restart),
    .outData(outData), .outValid(outValid),
    .outReady(outReady), .overrun(overrun),
    .overrunClr(overrunClr)
  );

  decimating_streamer #(.DATA_W(4), .OSR_LOG2(6)) dut4 (
    .clk(clk), .rst(rst), .adcInput(adc2),
    .sampleEn(en2), .restart(zero2),
    .outData(od4), .outValid(ov4),
    .outReady(rdy2), .overrun(or4),
    .overrunClr(zero2)
  );

  decimating_streamer #(.DATA_W(10), .OSR_LOG2(6)) dut10 (
    .clk(clk), .rst(rst), .adcInput(adc2),
    .sampleEn(en2), .restart(zero2),
    .outData(od10), .outValid(ov10),
    .outReady(rdy2), .overrun(or10),
    .overrunClr(zero2)
  );

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL main_unexpected: got %0h expected none", outData);
      end else begin
        chk("main_data", int'(outData), int'(q0.pop_front()));
        tq.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && rdy2) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL w4_unexpected: got %0h expected none", od4);
      end else
        chk("w4_data", int'(od4), int'(q1.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && ov10 && rdy2) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL w10_unexpected: got %0h expected none", od10);
      end else
        chk("w10_data", int'(od10), int'(q2.pop_front()));
    end
  end

  function automatic logic bit_of(input int mode, input int i);
    case (mode)
      1:       return 1'b1;
      2:       return (i % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      sampleEn = 0; adcInput = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      sampleEn = 0; adcInput = 1;
      @(posedge clk); #1;
    end
    adcInput = b; sampleEn = 1;
    @(posedge clk); #1;
    sampleEn = 0; adcInput = 0;
  endtask

  task automatic send_bits(input int n, input int mode);
    for (int i = 0; i < n; i++) send_bit(bit_of(mode, i), 0);
  endtask

  task automatic send2(input logic b);
    adc2 = b; en2 = 1;
    @(posedge clk); #1;
    en2 = 0; adc2 = 0;
  endtask

  initial begin
    rst = 1; adcInput = 0; sampleEn = 0; restart = 0;
    outReady = 0; overrunClr = 0;
    adc2 = 0; en2 = 0; rdy2 = 1; zero2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_data", int'(outData), 0);
    chk("rst_valid", int'(outValid), 0);
    chk("rst_overrun", int'(overrun), 0);

    // back-to-back windows: zeros, ones, alternating
    outReady = 1;
    tq.delete();
    q0.push_back(8'h00);
    send_bits(256, 0);
    chk("w0_valid", int'(outValid), 1);
    chk("w0_data", int'(outData), 8'h00);
    q0.push_back(8'hFF);
    send_bits(256, 1);
    q0.push_back(8'h80);
    send_bits(256, 2);
    idle(2);
    chk("stream_count", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("gap01", tq[1] - tq[0], 256);
      chk("gap12", tq[2] - tq[1], 256);
    end

    // sampleEn every third cycle
    q0.push_back(8'h40);
    for (int i = 0; i < 256; i++) send_bit(i < 64, 2);
    idle(2);

    // overrun: second window dropped
    outReady = 0;
    q0.push_back(8'h80);
    send_bits(256, 2);
    send_bits(256, 1);
    chk("ovr_data", int'(outData), 8'h80);
    chk("ovr_valid", int'(outValid), 1);
    chk("ovr_flag", int'(overrun), 1);
    outReady = 1;
    idle(1);
    chk("ovr_drained", int'(outValid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    overrunClr = 1;
    idle(1);
    overrunClr = 0;
    chk("ovr_clr", int'(overrun), 0);

    // clear and new overrun on the same cycle
    outReady = 0;
    q0.push_back(8'h00);
    send_bits(256, 0);
    chk("setwin_pre", int'(overrun), 0);
    send_bits(255, 0);
    overrunClr = 1;
    send_bit(0, 0);
    overrunClr = 0;
    chk("setwin_flag", int'(overrun), 1);
    outReady = 1;
    idle(1);
    overrunClr = 1;
    idle(1);
    overrunClr = 0;

    // completion coincides with a transfer
    outReady = 0;
    q0.push_back(8'hFF);
    send_bits(256, 1);
    q0.push_back(8'h00);
    send_bits(255, 0);
    outReady = 1;
    send_bit(0, 0);
    chk("pass_valid", int'(outValid), 1);
    chk("pass_data", int'(outData), 8'h00);
    chk("pass_overrun", int'(overrun), 0);
    idle(2);

    // restart discards partial window and its own bit
    send_bits(100, 1);
    restart = 1;
    send_bit(1, 0);
    restart = 0;
    q0.push_back(8'h00);
    send_bits(256, 0);
    idle(2);

    // reset with a pending sample and overrun
    outReady = 0;
    send_bits(256, 1);
    send_bits(256, 1);
    chk("prerst_overrun", int'(overrun), 1);
    chk("prerst_valid", int'(outValid), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("postrst_valid", int'(outValid), 0);
    chk("postrst_overrun", int'(overrun), 0);
    chk("postrst_data", int'(outData), 0);

    // reset mid-window clears the counter
    outReady = 1;
    send_bits(100, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q0.push_back(8'h00);
    send_bits(256, 0);
    idle(2);

    // narrow and wide output variants
    q1.push_back(16'hC);
    q2.push_back(16'h300);
    for (int i = 0; i < 64; i++) send2(i < 48);
    q1.push_back(16'hF);
    q2.push_back(16'h3F0);
    for (int i = 0; i < 64; i++) send2(1'b1);

    for (int k = 0; k < 20; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0)
        break;
      idle(1);
    end
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
